otter_lsu_split: RTL and testbench

//  Load/store initiator between the OTTER core and the data port (port 2) of the OTTER memory.

---
 rtl/otter_lsu_split.sv | 276 +++++++++++++++++++++++++++
 tb/tb_otter_lsu_split.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_lsu_split.sv
// otter_lsu_split
//   Load/store initiator between the OTTER core and data port 2 of the OTTER memory.
//   Takes one CPU request at a time, registers it, and drives the memory port. The memory
//   reads synchronously with one cycle of latency, so address/size/sign are held for the
//   capture cycle. Accesses that do not fit inside one aligned word are split:
//     - loads become two aligned word reads whose bytes are recombined here;
//     - stores become one byte write per cycle at ascending addresses.
//   Accesses at or above IO_BASE always go through as a single, unmodified access.
//
//   Build option: define LSU_MISALIGN_SPLIT_EN to build the split machinery. Without it,
//   misaligned memory-region accesses complete immediately with rsp_err_o=1 and no access.
//
// Ports
//   lsu_clk_i, lsu_rst_ni          clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      request handshake (ready only while idle)
//   req_we_i, req_addr_i, req_wdata_i, req_size_i, req_sign_i
//                                  store flag, byte address, right-justified store data,
//                                  size (0 byte, 1 half, 2 word, 3 illegal), 1 = unsigned
//   rsp_valid_o, rsp_rdata_o, rsp_err_o
//                                  one-cycle completion pulse, load data, error flag
//   mem_rden2_o, mem_we2_o, mem_addr2_o, mem_din2_o, mem_size_o, mem_sign_o, mem_dout2_i
//                                  memory data port

module otter_lsu_split #(
    parameter logic [31:0] IO_BASE = 32'h0001_0000
) (
    input  logic        lsu_clk_i,
    input  logic        lsu_rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_sign_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_rden2_o,
    output logic        mem_we2_o,
    output logic [31:0] mem_addr2_o,
    output logic [31:0] mem_din2_o,
    output logic [1:0]  mem_size_o,
    output logic        mem_sign_o,
    input  logic [31:0] mem_dout2_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIss,
        StRdCap,
        StWr,
        StRsp
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        StRd2Iss,
        StRd2Cap
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        split;     // the registered access is being split
    logic [31:0] word_base; // aligned word holding the first byte

    logic [1:0]  req_off;
    logic        req_io;
    logic        req_native;

    assign req_off    = req_addr_i[1:0];
    assign req_io     = req_addr_i >= IO_BASE;
    assign req_native = req_io
                      || (req_size_i == 2'd0)
                      || ((req_size_i == 2'd1) && (req_off != 2'd3))
                      || ((req_size_i == 2'd2) && (req_off == 2'd0));
    assign word_base  = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        split_q, split_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lo_q, lo_d;
    logic        req_cross;
    logic [1:0]  cnt_last;
    logic [63:0] pair;
    logic [31:0] shifted;
    logic [31:0] split_rdata;

    assign split     = split_q;
    // Second word of a split would reach into the IO region.
    assign req_cross = ({req_addr_i[31:2], 2'b00} + 32'd4) >= IO_BASE;
    assign cnt_last  = (size_q == 2'd1) ? 2'd1 : 2'd3;

    always_comb begin
        pair    = {mem_dout2_i, lo_q};
        shifted = pair[{addr_q[1:0], 3'b000} +: 32];
        if (size_q == 2'd1) begin
            split_rdata = sign_q ? {16'h0000, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
        end else begin
            split_rdata = shifted;
        end
    end
`else
    assign split = 1'b0;
`endif

    // Next state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d = split_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    size_d  = req_size_i;
                    sign_d  = req_sign_i;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_d = 1'b0;
                    cnt_d   = 2'd0;
`endif
                    if (req_size_i == 2'd3) begin
                        state_d = StRsp;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else if (req_native) begin
                        state_d = req_we_i ? StWr : StRdIss;
`ifdef LSU_MISALIGN_SPLIT_EN
                    end else if (!req_cross) begin
                        split_d = 1'b1;
                        state_d = req_we_i ? StWr : StRdIss;
`endif
                    end else begin
                        state_d = StRsp;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end
                end
            end
            StRdIss: state_d = StRdCap;
            StRdCap: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    lo_d    = mem_dout2_i;
                    state_d = StRd2Iss;
                end else
`endif
                begin
                    // Native reads come back already sized and extended by the memory.
                    rdata_d = mem_dout2_i;
                    err_d   = 1'b0;
                    state_d = StRsp;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            StRd2Iss: state_d = StRd2Cap;
            StRd2Cap: begin
                rdata_d = split_rdata;
                err_d   = 1'b0;
                state_d = StRsp;
            end
`endif
            StWr: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q && (cnt_q != cnt_last)) begin
                    cnt_d = cnt_q + 2'd1;
                end else
`endif
                begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = StRsp;
                end
            end
            StRsp:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StRsp);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        mem_rden2_o = 1'b0;
        mem_we2_o   = 1'b0;
        mem_addr2_o = 32'h0;
        mem_din2_o  = 32'h0;
        mem_size_o  = 2'd0;
        mem_sign_o  = 1'b0;
        unique case (state_q)
            StRdIss, StRdCap: begin
                mem_rden2_o = (state_q == StRdIss);
                if (split) begin
                    mem_addr2_o = word_base;
                    mem_size_o  = 2'd2;
                end else begin
                    mem_addr2_o = addr_q;
                    mem_size_o  = size_q;
                    mem_sign_o  = sign_q;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            StRd2Iss, StRd2Cap: begin
                mem_rden2_o = (state_q == StRd2Iss);
                mem_addr2_o = word_base + 32'd4;
                mem_size_o  = 2'd2;
            end
`endif
            StWr: begin
                mem_we2_o = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    mem_addr2_o = addr_q + {30'd0, cnt_q};
                    mem_din2_o  = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
                end else
`endif
                begin
                    mem_addr2_o = addr_q;
                    mem_din2_o  = wdata_q;
                    mem_size_o  = size_q;
                    mem_sign_o  = sign_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge lsu_clk_i or negedge lsu_rst_ni) begin
        if (!lsu_rst_ni) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= 1'b0;
            cnt_q   <= 2'd0;
            lo_q    <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= split_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
`endif
        end
    end

endmodule

// File: tb/tb_otter_lsu_split.sv
// Bench for otter_lsu_split: byte-array memory, byte-level reference model, per-cycle compare.
module tb_otter_lsu_split;

    localparam logic [31:0] IoBase = 32'h0001_0000;
    localparam int MemSize = 2560;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_ready, rsp_valid, rsp_err, mem_rden, mem_we, mem_sign;
    logic [31:0] rsp_rdata, mem_addr, mem_din;
    logic [31:0] mem_dout = 32'h0;
    logic [1:0]  mem_size;

    otter_lsu_split dut (
        .lsu_clk_i   (clk),
        .lsu_rst_ni  (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_size_i  (req_size),
        .req_sign_i  (req_sign),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_rden2_o (mem_rden),
        .mem_we2_o   (mem_we),
        .mem_addr2_o (mem_addr),
        .mem_din2_o  (mem_din),
        .mem_size_o  (mem_size),
        .mem_sign_o  (mem_sign),
        .mem_dout2_i (mem_dout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, {31'd0, got}, {31'd0, exp});
    endtask

    // Two byte memories: dmem is what the DUT talks to, rmem is the model's view.
    logic [7:0] dmem [MemSize];
    logic [7:0] rmem [MemSize];

    function automatic int midx(input logic [31:0] a);
        if (a < 32'h800) return int'(a);
        if (a >= 32'hFF00 && a < 32'h10100) return int'(a - 32'hFF00) + 2048;
        return -1;
    endfunction

    function automatic logic [7:0] dbyte(input logic [31:0] a);
        int i = midx(a);
        return (i < 0) ? 8'h00 : dmem[i];
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        int i = midx(a);
        return (i < 0) ? 8'h00 : rmem[i];
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] v, input logic [1:0] sz,
                                        input logic uns);
        if (sz == 2'd0) return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (sz == 2'd1) return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] dload(input logic [31:0] a, input logic [1:0] sz,
                                          input logic uns);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = dbyte(a + 32'(i));
        return ext(v, sz, uns);
    endfunction

    function automatic logic [31:0] rload(input logic [31:0] a, input logic [1:0] sz,
                                          input logic uns);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = rbyte(a + 32'(i));
        return ext(v, sz, uns);
    endfunction

    // Memory behind port 2: sized writes, registered sized/extended reads.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i < nbytes(mem_size) && midx(mem_addr + 32'(i)) >= 0)
                    dmem[midx(mem_addr + 32'(i))] <= mem_din[8*i +: 8];
            end
        end
        if (mem_rden) mem_dout <= dload(mem_addr, mem_size, mem_sign);
    end

    // Expected per-cycle behaviour of the current transaction (index = cycles after accept).
    int          exp_len = 1;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;
    logic        e_rden [8];
    logic        e_we [8];
    logic        e_chk [8];
    logic        e_chksign [8];
    logic [31:0] e_addr [8];
    logic [31:0] e_din [8];
    logic [31:0] e_dmask [8];
    logic [1:0]  e_size [8];
    logic        e_sign [8];
    logic        busy = 1'b0;
    logic        skip = 1'b1;
    int          acc_cyc = 0;
    int          cmp_n;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns);
        int          nb = nbytes(sz);
        int          off = int'(addr[1:0]);
        logic [31:0] a0 = addr & ~32'd3;
        bit          fits, err, split_on;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_on = 1'b1;
`else
        split_on = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            e_rden[i] = 0; e_we[i] = 0; e_chk[i] = 0; e_chksign[i] = 0;
            e_addr[i] = 0; e_din[i] = 0; e_dmask[i] = 0; e_size[i] = 0; e_sign[i] = 0;
        end
        fits = (addr >= IoBase) || (off + nb <= 4);
        err  = (sz == 2'd3) || (!fits && (!split_on || (a0 + 32'd4 >= IoBase)));
        exp_rdata = 32'h0;
        exp_err   = err;
        if (err) begin
            exp_len = 1;
        end else if (fits && we) begin
            exp_len = 2;
            e_we[0] = 1; e_chk[0] = 1; e_addr[0] = addr; e_size[0] = sz;
            e_din[0] = wd; e_dmask[0] = 32'hFFFF_FFFF;
        end else if (fits) begin
            exp_len = 3;
            e_rden[0] = 1;
            for (int i = 0; i < 2; i++) begin
                e_chk[i] = 1; e_chksign[i] = 1; e_addr[i] = addr; e_size[i] = sz;
                e_sign[i] = uns;
            end
            exp_rdata = rload(addr, sz, uns);
        end else if (we) begin
            exp_len = nb + 1;
            for (int k = 0; k < nb; k++) begin
                e_we[k] = 1; e_chk[k] = 1; e_addr[k] = addr + 32'(k); e_size[k] = 2'd0;
                e_din[k] = (wd >> (8 * k)) & 32'hFF; e_dmask[k] = 32'hFF;
            end
        end else begin
            exp_len = 5;
            e_rden[0] = 1; e_rden[2] = 1;
            for (int i = 0; i < 4; i++) begin
                e_chk[i] = 1; e_chksign[i] = 1; e_size[i] = 2'd2; e_sign[i] = 0;
                e_addr[i] = (i < 2) ? a0 : a0 + 32'd4;
            end
            exp_rdata = rload(addr, sz, uns);
        end
        if (we && !err) begin
            for (int k = 0; k < nb; k++) begin
                if (midx(addr + 32'(k)) >= 0) rmem[midx(addr + 32'(k))] = wd[8*k +: 8];
            end
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && !skip) begin
            cmp_n = cyc - acc_cyc;
            chk1("rden_we_exclusive", mem_rden & mem_we, 1'b0);
            if (busy && cmp_n < exp_len) begin
                chk1("ready_busy", req_ready, 1'b0);
                chk1("rsp_valid", rsp_valid, cmp_n == exp_len - 1);
                chk1("mem_rden", mem_rden, e_rden[cmp_n]);
                chk1("mem_we", mem_we, e_we[cmp_n]);
                if (e_chk[cmp_n]) begin
                    chk("mem_addr", mem_addr, e_addr[cmp_n]);
                    chk({30'd0, mem_size} == 32'd0 ? "mem_size" : "mem_size",
                        {30'd0, mem_size}, {30'd0, e_size[cmp_n]});
                end
                if (e_chksign[cmp_n]) chk1("mem_sign", mem_sign, e_sign[cmp_n]);
                if (e_we[cmp_n]) chk("mem_din", mem_din & e_dmask[cmp_n], e_din[cmp_n]);
                if (cmp_n == exp_len - 1) begin
                    chk("rsp_rdata", rsp_rdata, exp_rdata);
                    chk1("rsp_err", rsp_err, exp_err);
                    last_rdata = exp_rdata;
                    last_err   = exp_err;
                end
            end else begin
                chk1("ready_idle", req_ready, 1'b1);
                chk1("rsp_valid_idle", rsp_valid, 1'b0);
                chk1("rden_idle", mem_rden, 1'b0);
                chk1("we_idle", mem_we, 1'b0);
                chk("rdata_hold", rsp_rdata, last_rdata);
                chk1("err_hold", rsp_err, last_err);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, output logic [31:0] rd,
                          output logic er, output int lat);
        model(we, addr, wd, sz, uns);
        @(posedge clk); #2;
        req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_sign = uns;
        req_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        busy = 1'b1;
        // Request fields must have been captured; scramble them.
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_sign = 1'($urandom);
        lat = -1; rd = 32'h0; er = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin
                rd = rsp_rdata; er = rsp_err; lat = i + 1;
                break;
            end
        end
        if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        busy = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_ready"}, req_ready, 1'b1);
        chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk1({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk1({tag, "_rden"}, mem_rden, 1'b0);
        chk1({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_din"}, mem_din, 32'h0);
        chk({tag, "_size"}, {30'd0, mem_size}, 32'h0);
        chk1({tag, "_sign"}, mem_sign, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          mism;
        logic [31:0] a;
        for (int i = 0; i < MemSize; i++) begin
            dmem[i] = 8'($urandom);
            rmem[i] = dmem[i];
        end
        a = 32'h100;
        for (int i = 0; i < 8; i++) begin
            dmem[midx(a + 32'(i))] = 8'(64'h1122_3344_8899_AABB >> (8 * i));
            rmem[midx(a + 32'(i))] = dmem[midx(a + 32'(i))];
        end
        dmem[midx(32'h200)] = 8'h5A;
        rmem[midx(32'h200)] = 8'h5A;

        #3 chk_reset_vals("por");
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
        skip = 1'b0;

        // Native word load.
        do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd, er, lat);
        chk("lw100_data", rd, 32'h8899_AABB);
        chk1("lw100_err", er, 1'b0);
        chk("lw100_lat", 32'(lat), 32'd3);
        do_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, rd, er, lat);
        chk("lb103_data", rd, 32'hFFFF_FF88);

`ifdef LSU_MISALIGN_SPLIT_EN
        do_req(1'b0, 32'h103, 32'h0, 2'd1, 1'b0, rd, er, lat);
        chk("lh103_data", rd, 32'h0000_4488);
        chk("lh103_lat", 32'(lat), 32'd5);
        do_req(1'b0, 32'h103, 32'h0, 2'd1, 1'b1, rd, er, lat);
        chk("lhu103_data", rd, 32'h0000_4488);
        do_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, rd, er, lat);
        chk("lw102_data", rd, 32'h3344_8899);
        chk1("lw102_err", er, 1'b0);
        do_req(1'b1, 32'h201, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, er, lat);
        chk("sw201_lat", 32'(lat), 32'd5);
        chk("sw201_b200", {24'h0, dbyte(32'h200)}, 32'h5A);
        chk("sw201_b201", {24'h0, dbyte(32'h201)}, 32'hEF);
        chk("sw201_b202", {24'h0, dbyte(32'h202)}, 32'hBE);
        chk("sw201_b203", {24'h0, dbyte(32'h203)}, 32'hAD);
        chk("sw201_b204", {24'h0, dbyte(32'h204)}, 32'hDE);
        do_req(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, rd, er, lat);
        chk("lw200_back", rd, 32'hADBE_EF5A);
`else
        do_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, rd, er, lat);
        chk("lw102_nosplit_err", {31'd0, er}, 32'd1);
        chk("lw102_nosplit_data", rd, 32'h0);
        chk("lw102_nosplit_lat", 32'(lat), 32'd1);
`endif

        do_req(1'b0, 32'h0000_FFFE, 32'h0, 2'd2, 1'b0, rd, er, lat);
        chk1("lw_fffe_err", er, 1'b1);
        chk("lw_fffe_lat", 32'(lat), 32'd1);
        do_req(1'b0, 32'h104, 32'h0, 2'd3, 1'b0, rd, er, lat);
        chk1("size3_err", er, 1'b1);
        chk("size3_data", rd, 32'h0);
        do_req(1'b1, 32'h0001_1000, 32'hCAFE_F00D, 2'd2, 1'b0, rd, er, lat);
        chk1("sw_io_err", er, 1'b0);
        chk("sw_io_lat", 32'(lat), 32'd2);

        // Reset asserted during the capture cycle of a load.
        do_req(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, rd, er, lat);
        chk("lw104_data", rd, 32'h1122_3344);
        skip = 1'b1;
        @(posedge clk); #2;
        req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_sign = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk1("rdcap_rden", mem_rden, 1'b0);
        chk("rdcap_addr", mem_addr, 32'h100);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        #10 rst_n = 1'b1;
        last_rdata = 32'h0;
        last_err   = 1'b0;
        @(negedge clk); #1;
        chk1("post_rst_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        skip = 1'b0;

        for (int t = 0; t < 300; t++) begin
            int r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 32'h3FF));
            else if (r == 7) a = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
            else             a = 32'h0001_0000 + 32'($urandom_range(0, 31));
            do_req(1'($urandom), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom),
                   rd, er, lat);
        end

        mism = 0;
        for (int i = 0; i < MemSize; i++) if (dmem[i] !== rmem[i]) mism++;
        chk("mem_final_mismatches", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
